// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and a constant-width helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int NB_DATA_DEF  = 8;
  localparam int NB_TICKS_DEF = 16;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } rx_state_e;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receiver output bundle: parallel byte plus the done / framing-error strobes.
interface uart_rx_oversampled_if #(
  parameter int NB_DATA = uart_pkg::NB_DATA_DEF
);

  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  modport master (output o_data, output o_rx_done, output o_frame_err);
  modport slave  (input  o_data, input  o_rx_done, input  o_frame_err);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; the reset value is chosen
// so an idle-high line does not look like activity coming out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: start / NB_DATA data bits LSB-first / stop, sampled at
// mid-bit using a shared baud tick running at NB_TICKS per bit.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_TICKS = NB_TICKS_DEF
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick,
  input  logic                  i_rx,
  uart_rx_oversampled_if.master rx_if
);

  localparam int TW = clog2(NB_TICKS);
  localparam int BW = clog2(NB_DATA);
  localparam logic [TW-1:0] TICK_LAST = TW'(NB_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(NB_TICKS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  rx_state_e          state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               rx_s;
  logic               rx_prev;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .d       (i_rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_prev <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rx_prev <= rx_s;
    end
  end

  // A start is only a true falling edge, so a line stuck low after a break
  // cannot retrigger the receiver until it has gone high again.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_q == HALF_LAST) begin
            if (!rx_s) begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[NB_DATA-1:1]};
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_q == TICK_LAST) begin
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_rx_done   = done_q;
  assign rx_if.o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed plus randomized frames against a frame-level model of the receiver.
module tb_uart_rx_oversampled;

  localparam int NB_DATA  = 8;
  localparam int NB_TICKS = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = NB_TICKS * TICK_DIV;

  logic clk;
  logic i_rst_n;
  logic i_tick;
  logic i_rx;
  logic tick_en;

  int checks = 0;
  int errors = 0;

  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [NB_DATA-1:0] done_data = '0;

  int exp_done = 0;
  int exp_err  = 0;
  logic [NB_DATA-1:0] exp_data = '0;

  uart_rx_oversampled_if #(.NB_DATA(NB_DATA)) rx_if ();

  uart_rx_oversampled #(
    .NB_DATA  (NB_DATA),
    .NB_TICKS (NB_TICKS)
  ) dut (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_tick),
    .i_rx    (i_rx),
    .rx_if   (rx_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk wide every TICK_DIV clocks while enabled.
  initial begin
    int div;
    div    = 0;
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      i_tick = tick_en && (div == TICK_DIV - 1);
      div    = (div + 1) % TICK_DIV;
    end
  end

  always @(negedge clk) begin
    if (rx_if.o_rx_done) begin
      done_cnt  = done_cnt + 1;
      done_data = rx_if.o_data;
    end
    if (rx_if.o_frame_err) err_cnt = err_cnt + 1;
    if (rx_if.o_rx_done && rx_if.o_frame_err) both_cnt = both_cnt + 1;
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic driveFrame(input logic [NB_DATA-1:0] value, input logic stop_bit, input int gap);
    i_rx = 1'b0;
    waitClk(BIT_CLK);
    for (int i = 0; i < NB_DATA; i++) begin
      i_rx = value[i];
      waitClk(BIT_CLK);
    end
    i_rx = stop_bit;
    waitClk(BIT_CLK);
    i_rx = 1'b1;
    waitClk(gap);
  endtask

  // Frame-level model: a good stop delivers the byte, a bad one only flags.
  task automatic applyStimulus(input logic [NB_DATA-1:0] value, input logic stop_ok, input int gap);
    driveFrame(value, stop_ok, gap);
    if (stop_ok) begin
      exp_done = exp_done + 1;
      exp_data = value;
    end else begin
      exp_err = exp_err + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
      else begin
        errors = errors + 1;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_done_count"}, done_cnt, exp_done);
    checkOutput({tag, "_err_count"}, err_cnt, exp_err);
    checkOutput({tag, "_data"}, 32'(rx_if.o_data), 32'(exp_data));
  endtask

  initial begin
    logic [NB_DATA-1:0] rnd_byte;
    logic               rnd_ok;
    int                 rnd_gap;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    tick_en = 1'b1;
    waitClk(5);
    checkOutput("reset_data", 32'(rx_if.o_data), 32'h0);
    checkOutput("reset_done", 32'(rx_if.o_rx_done), 32'h0);
    checkOutput("reset_err", 32'(rx_if.o_frame_err), 32'h0);
    i_rst_n = 1'b1;
    waitClk(20);

    applyStimulus(8'hA5, 1'b1, 20);
    checkModel("frame_a5");
    checkOutput("a5_pulse_data", 32'(done_data), 32'hA5);

    applyStimulus(8'h00, 1'b1, 0);
    checkOutput("b2b_first_data", 32'(done_data), 32'h00);
    applyStimulus(8'hFF, 1'b1, 20);
    checkModel("b2b_ff");

    i_rx = 1'b0;
    waitClk(4 * TICK_DIV);
    i_rx = 1'b1;
    waitClk(BIT_CLK);
    checkModel("glitch");
    applyStimulus(8'h3C, 1'b1, 20);
    checkModel("after_glitch_3c");

    applyStimulus(8'h55, 1'b0, 20);
    checkModel("bad_stop_55");

    i_rx = 1'b0;
    waitClk(12 * BIT_CLK);
    exp_err = exp_err + 1;
    checkModel("break");
    i_rx = 1'b1;
    waitClk(BIT_CLK);
    applyStimulus(8'hC3, 1'b1, 20);
    checkModel("after_break_c3");

    i_rx = 1'b0;
    waitClk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i == 0);
      waitClk(BIT_CLK);
    end
    i_rst_n = 1'b0;
    waitClk(3);
    exp_data = '0;
    checkModel("reset_mid_frame");
    i_rx = 1'b1;
    waitClk(2);
    i_rst_n = 1'b1;
    waitClk(20);
    checkModel("after_reset_release");
    applyStimulus(8'h7E, 1'b1, 20);
    checkModel("after_reset_7e");

    tick_en = 1'b0;
    driveFrame(8'h12, 1'b1, BIT_CLK);
    checkModel("no_ticks");
    tick_en = 1'b1;
    waitClk(2 * BIT_CLK);
    checkModel("ticks_resumed");

    for (int n = 0; n < 20; n++) begin
      rnd_byte = NB_DATA'($urandom);
      rnd_ok   = ($urandom_range(0, 4) != 0);
      rnd_gap  = rnd_ok ? $urandom_range(0, 40) : $urandom_range(8, 40);
      applyStimulus(rnd_byte, rnd_ok, rnd_gap);
      checkModel($sformatf("random_%0d", n));
    end

    checkOutput("done_err_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
